// File: rtl/sim_run_ctrl.sv
// Run controller for CPU simulation benches: core reset/halt, cycle budget, tohost exit detection.
// Optional hang detector on a frozen IADDR is enabled with SIM_RUN_CTRL_STALL_DET_EN.
module sim_run_ctrl #(
    parameter int          RST_CYCLES   = 2,
    parameter int          MAX_CYCLES   = 100,
    parameter logic [31:0] TOHOST_ADDR  = 32'h0000_1000,
    parameter int          CW           = 32,
    parameter int          STALL_CYCLES = 16
) (
    input  logic          CLK,
    input  logic          RESN,
    input  logic [31:0]   IADDR,
    input  logic [31:0]   DADDR,
    input  logic [31:0]   DATAO,
    input  logic          WR,
    input  logic [3:0]    BE,
    output logic          CPU_RES,
    output logic          HLT,
    output logic          DONE,
    output logic          PASS,
    output logic          FAIL,
    output logic          TIMEOUT,
    output logic [30:0]   EXIT_CODE,
    output logic [CW-1:0] CYCLES
);

    localparam logic [1:0] S_HOLD = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int HW = $clog2(RST_CYCLES + 1);

    logic [1:0]    state;
    logic [HW-1:0] hold_cnt;
    logic          exit_hit;
    logic          stall_hit;
    logic          tmo_hit;

    // Stores with bit0 clear or partial byte enables are heartbeats, not exits.
    assign exit_hit = WR && (DADDR == TOHOST_ADDR) && (BE == 4'hF) && DATAO[0];
    assign tmo_hit  = (CYCLES == CW'(MAX_CYCLES - 1));
    assign HLT      = (state == S_DONE);

`ifdef SIM_RUN_CTRL_STALL_DET_EN
    localparam int SW = $clog2(STALL_CYCLES + 1);

    logic [31:0]   iaddr_q;
    logic [SW-1:0] stall_cnt;

    assign stall_hit = (state == S_RUN) && (IADDR == iaddr_q) &&
                       (stall_cnt == SW'(STALL_CYCLES - 1));

    always_ff @(posedge CLK) begin
        if (!RESN) begin
            iaddr_q   <= '0;
            stall_cnt <= '0;
        end else begin
            iaddr_q <= IADDR;
            if (state != S_RUN)
                stall_cnt <= '0;
            else if (IADDR == iaddr_q)
                stall_cnt <= stall_cnt + SW'(1);
            else
                stall_cnt <= '0;
        end
    end
`else
    logic unused_stall;

    assign stall_hit    = 1'b0;
    assign unused_stall = ^{IADDR, 32'(STALL_CYCLES)};
`endif

    always_ff @(posedge CLK) begin
        if (!RESN) begin
            state     <= S_HOLD;
            hold_cnt  <= '0;
            CPU_RES   <= 1'b1;
            DONE      <= 1'b0;
            PASS      <= 1'b0;
            FAIL      <= 1'b0;
            TIMEOUT   <= 1'b0;
            EXIT_CODE <= '0;
            CYCLES    <= '0;
        end else begin
            case (state)
                S_HOLD: begin
                    hold_cnt <= hold_cnt + HW'(1);
                    if (hold_cnt == HW'(RST_CYCLES - 1)) begin
                        state   <= S_RUN;
                        CPU_RES <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (CYCLES != '1)
                        CYCLES <= CYCLES + CW'(1);
                    // Exit beats stall beats timeout when they land on the same edge.
                    if (exit_hit) begin
                        EXIT_CODE <= DATAO[31:1];
                        DONE      <= 1'b1;
                        PASS      <= (DATAO[31:1] == 31'd0);
                        FAIL      <= (DATAO[31:1] != 31'd0);
                        state     <= S_DONE;
                    end else if (stall_hit) begin
                        EXIT_CODE <= 31'h7FFF_FFFF;
                        DONE      <= 1'b1;
                        FAIL      <= 1'b1;
                        state     <= S_DONE;
                    end else if (tmo_hit) begin
                        TIMEOUT   <= 1'b1;
                        DONE      <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Scoreboard bench for sim_run_ctrl: expected end-of-run status is queued when the
// triggering stimulus is driven and compared when DONE rises.
module tb_sim_run_ctrl;

    localparam logic [31:0] TOHOST = 32'h0000_1000;

    logic        CLK = 1'b0;
    logic        RESN = 1'b0;
    logic [31:0] IADDR = 32'h0;
    logic [31:0] DADDR = 32'h0;
    logic [31:0] DATAO = 32'h0;
    logic        WR = 1'b0;
    logic [3:0]  BE = 4'h0;
    logic        CPU_RES, HLT, DONE, PASS, FAIL, TIMEOUT;
    logic [30:0] EXIT_CODE;
    logic [31:0] CYCLES;

    int n_checks = 0;
    int n_fail   = 0;
    bit hold_iaddr = 1'b0;
    bit done_prev  = 1'b0;

    typedef struct {
        logic        pass;
        logic        fail;
        logic        tmo;
        logic [30:0] code;
        logic [31:0] cyc;
    } exp_t;

    exp_t sb[$];

    sim_run_ctrl #(
        .RST_CYCLES(2), .MAX_CYCLES(100), .TOHOST_ADDR(TOHOST), .CW(32), .STALL_CYCLES(16)
    ) dut (
        .CLK(CLK), .RESN(RESN), .IADDR(IADDR), .DADDR(DADDR), .DATAO(DATAO),
        .WR(WR), .BE(BE), .CPU_RES(CPU_RES), .HLT(HLT), .DONE(DONE), .PASS(PASS),
        .FAIL(FAIL), .TIMEOUT(TIMEOUT), .EXIT_CODE(EXIT_CODE), .CYCLES(CYCLES)
    );

    always #5 CLK = ~CLK;

    // Scoreboard consumer: one entry per DONE rising edge.
    always @(negedge CLK) begin
        if (DONE === 1'b1 && !done_prev) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_done: DONE rose with empty queue, cycles=%0d", CYCLES);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({PASS, FAIL, TIMEOUT, HLT} !== {e.pass, e.fail, e.tmo, 1'b1}) begin
                    n_fail++;
                    $display("FAIL sb_flags: got P/F/T/H=%b%b%b%b want %b%b%b1",
                             PASS, FAIL, TIMEOUT, HLT, e.pass, e.fail, e.tmo);
                end
                n_checks++;
                if (EXIT_CODE !== e.code) begin
                    n_fail++;
                    $display("FAIL sb_exit_code: got %h want %h", EXIT_CODE, e.code);
                end
                n_checks++;
                if (CYCLES !== e.cyc) begin
                    n_fail++;
                    $display("FAIL sb_cycles: got %0d want %0d", CYCLES, e.cyc);
                end
            end
        end
        done_prev = (DONE === 1'b1);
    end

    task automatic step();
        @(negedge CLK);
        if (!hold_iaddr) IADDR = IADDR + 32'd4;
    endtask

    task automatic store(input logic [31:0] data, input logic [3:0] be);
        WR = 1'b1; DADDR = TOHOST; DATAO = data; BE = be;
        step();
        WR = 1'b0; DADDR = 32'h0; DATAO = 32'h0; BE = 4'h0;
    endtask

    task automatic push(input logic p, input logic f, input logic t,
                        input logic [30:0] code, input logic [31:0] cyc);
        exp_t e;
        e.pass = p; e.fail = f; e.tmo = t; e.code = code; e.cyc = cyc;
        sb.push_back(e);
    endtask

    // Leaves the DUT in RUN with CYCLES=0 (first RUN edge still ahead).
    task automatic do_reset();
        RESN = 1'b0; WR = 1'b0;
        repeat (3) step();
        RESN = 1'b1;
        repeat (2) step();
    endtask

    task automatic wait_sb(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            step();
            n++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL wait_done: %0d expected results pending after %0d cycles", sb.size(), budget);
            sb.delete();
        end
    endtask

    task automatic test_reset();
        RESN = 1'b0; WR = 1'b0;
        repeat (3) step();
        n_checks++;
        if ({CPU_RES, HLT, DONE, PASS, FAIL, TIMEOUT} !== 6'b100000 || EXIT_CODE !== 31'd0 || CYCLES !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_vals: res/hlt/d/p/f/t=%b%b%b%b%b%b code=%h cyc=%0d want 100000 0 0",
                     CPU_RES, HLT, DONE, PASS, FAIL, TIMEOUT, EXIT_CODE, CYCLES);
        end
        RESN = 1'b1;
        n_checks++;
        if (CPU_RES !== 1'b1) begin n_fail++; $display("FAIL hold_c0: CPU_RES=%b want 1", CPU_RES); end
        step();
        n_checks++;
        if (CPU_RES !== 1'b1 || CYCLES !== 32'd0) begin
            n_fail++; $display("FAIL hold_c1: CPU_RES=%b cyc=%0d want 1 0", CPU_RES, CYCLES);
        end
        step();
        n_checks++;
        if (CPU_RES !== 1'b0 || CYCLES !== 32'd0) begin
            n_fail++; $display("FAIL hold_release: CPU_RES=%b cyc=%0d want 0 0", CPU_RES, CYCLES);
        end
        step();
        n_checks++;
        if (CYCLES !== 32'd1 || DONE !== 1'b0 || HLT !== 1'b0) begin
            n_fail++; $display("FAIL first_run: cyc=%0d done=%b hlt=%b want 1 0 0", CYCLES, DONE, HLT);
        end
    endtask

    task automatic test_pass_exit();
        do_reset();
        repeat (10) step();
        n_checks++;
        if (CYCLES !== 32'd10) begin n_fail++; $display("FAIL pass_pre: cyc=%0d want 10", CYCLES); end
        push(1'b1, 1'b0, 1'b0, 31'd0, 32'd11);
        store(32'h1, 4'hF);
        wait_sb(5);
        repeat (3) step();
        store(32'h7, 4'hF);
        n_checks++;
        if (CYCLES !== 32'd11 || EXIT_CODE !== 31'd0 || PASS !== 1'b1 || FAIL !== 1'b0 || HLT !== 1'b1) begin
            n_fail++;
            $display("FAIL pass_sticky: cyc=%0d code=%h p=%b f=%b h=%b want 11 0 1 0 1",
                     CYCLES, EXIT_CODE, PASS, FAIL, HLT);
        end
    endtask

    task automatic test_fail_exit();
        do_reset();
        repeat (5) step();
        store(32'h4, 4'hF);
        store(32'h1, 4'h3);
        n_checks++;
        if (DONE !== 1'b0 || CYCLES !== 32'd7 || CPU_RES !== 1'b0) begin
            n_fail++; $display("FAIL heartbeat: done=%b cyc=%0d res=%b want 0 7 0", DONE, CYCLES, CPU_RES);
        end
        push(1'b0, 1'b1, 1'b0, 31'd3, 32'd8);
        store(32'h7, 4'hF);
        wait_sb(5);
    endtask

    task automatic test_timeout();
        do_reset();
        repeat (99) step();
        n_checks++;
        if (DONE !== 1'b0 || CYCLES !== 32'd99 || HLT !== 1'b0) begin
            n_fail++; $display("FAIL tmo_pre: done=%b cyc=%0d hlt=%b want 0 99 0", DONE, CYCLES, HLT);
        end
        push(1'b0, 1'b0, 1'b1, 31'd0, 32'd100);
        wait_sb(5);
        repeat (2) step();
        n_checks++;
        if (CYCLES !== 32'd100 || TIMEOUT !== 1'b1 || HLT !== 1'b1) begin
            n_fail++; $display("FAIL tmo_frozen: cyc=%0d t=%b h=%b want 100 1 1", CYCLES, TIMEOUT, HLT);
        end
    endtask

    task automatic test_collide();
        do_reset();
        repeat (99) step();
        push(1'b1, 1'b0, 1'b0, 31'd0, 32'd100);
        store(32'h1, 4'hF);
        wait_sb(5);
    endtask

    task automatic test_reset_midrun();
        do_reset();
        repeat (20) step();
        push(1'b0, 1'b1, 1'b0, 31'd1, 32'd21);
        store(32'h3, 4'hF);
        wait_sb(5);
        RESN = 1'b0;
        step();
        n_checks++;
        if ({CPU_RES, HLT, DONE, PASS, FAIL, TIMEOUT} !== 6'b100000 || EXIT_CODE !== 31'd0 || CYCLES !== 32'd0) begin
            n_fail++;
            $display("FAIL midrun_clear: res/hlt/d/p/f/t=%b%b%b%b%b%b code=%h cyc=%0d",
                     CPU_RES, HLT, DONE, PASS, FAIL, TIMEOUT, EXIT_CODE, CYCLES);
        end
        RESN = 1'b1;
        step();
        n_checks++;
        if (CPU_RES !== 1'b1) begin n_fail++; $display("FAIL midrun_hold: CPU_RES=%b want 1", CPU_RES); end
        step();
        step();
        n_checks++;
        if (CPU_RES !== 1'b0 || CYCLES !== 32'd1) begin
            n_fail++; $display("FAIL midrun_restart: res=%b cyc=%0d want 0 1", CPU_RES, CYCLES);
        end
        repeat (4) step();
        RESN = 1'b0;
        step();
        RESN = 1'b1;
        n_checks++;
        if (CYCLES !== 32'd0 || CPU_RES !== 1'b1) begin
            n_fail++; $display("FAIL run_pulse: cyc=%0d res=%b want 0 1", CYCLES, CPU_RES);
        end
    endtask

`ifdef SIM_RUN_CTRL_STALL_DET_EN
    task automatic test_stall();
        hold_iaddr = 1'b1;
        IADDR = 32'h40;
        do_reset();
        push(1'b0, 1'b1, 1'b0, 31'h7FFF_FFFF, 32'd16);
        wait_sb(40);
        hold_iaddr = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_pass_exit();
        test_fail_exit();
        test_timeout();
        test_collide();
        test_reset_midrun();
`ifdef SIM_RUN_CTRL_STALL_DET_EN
        test_stall();
`endif
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
